// File: rtl/ramb18_burst_reader.sv
// ramb18_burst_reader
//   Read-side sequencer for a 1024x18 dual-read-port RAMB18 buffer. A start
//   command streams a contiguous burst: even words come through port A and odd
//   words through port B, giving two words per clock. The words go out as a
//   36-bit valid/ready stream with backpressure.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, base_addr, count   burst command (start is sampled only when idle)
//   busy, done                status; done is a one-cycle pulse after drain
//   read_addr_a/b             registered read addresses to the buffer
//   read_data_a/b             buffer read data, one cycle after the address
//   out_data/mask/last        beat payload ([17:0] earlier word, [35:18] later)
//   out_valid, out_ready      stream handshake
//   stall_cycles              only with BURST_READER_STALL_CNT_EN defined:
//                             saturating count of valid && !ready cycles
//
// Optional feature macro: BURST_READER_STALL_CNT_EN
module ramb18_burst_reader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   read_addr_a,
    input  logic [DATA_W-1:0]   read_data_a,
    output logic [ADDR_W-1:0]   read_addr_b,
    input  logic [DATA_W-1:0]   read_data_b,
    output logic [2*DATA_W-1:0] out_data,
    output logic [1:0]          out_mask,
    output logic                out_last,
    output logic                out_valid,
`ifdef BURST_READER_STALL_CNT_EN
    output logic [15:0]         stall_cycles,
`endif
    input  logic                out_ready
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    // FIFO entry layout: {last, mask[1:0], data}
    localparam int unsigned EntW = 2 * DATA_W + 3;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    // Two-stage in-flight tracking: s1 = address on the bus, s2 = data on the bus.
    logic                s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [1:0]          s1_mask_q, s1_mask_d, s2_mask_q, s2_mask_d;
    logic                s1_last_q, s1_last_d, s2_last_q, s2_last_d;

    logic [EntW-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [2*DATA_W-1:0] hold_data_q, hold_data_d;

    logic                issue, push, pop;
    logic [ADDR_W-1:0]   src_cur;
    logic [ADDR_W:0]     src_rem, step;
    logic [CntW:0]       used;
    logic [EntW-1:0]     head, push_entry;

    assign out_valid = (fifo_cnt_q != '0);
    assign head      = fifo_mem_q[rd_ptr_q];
    assign push      = s2_vld_q;
    assign pop       = out_valid && out_ready;
    // Upper word is zeroed for a single-word beat.
    assign push_entry = {s2_last_q, s2_mask_q,
                         (s2_mask_q[1] ? read_data_b : '0), read_data_a};
    // Credits: buffered beats plus reads still in the pipeline.
    assign used = (CntW+1)'(fifo_cnt_q) + (CntW+1)'(s1_vld_q) + (CntW+1)'(s2_vld_q);

    assign out_data    = out_valid ? head[2*DATA_W-1:0] : hold_data_q;
    assign out_mask    = out_valid ? head[EntW-2:EntW-3] : 2'b00;
    assign out_last    = out_valid ? head[EntW-1] : 1'b0;
    assign read_addr_a = addr_a_q;
    assign read_addr_b = addr_b_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StFin);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        s1_mask_d = s1_mask_q;
        s1_last_d = s1_last_q;
        s2_vld_d  = s1_vld_q;
        s2_mask_d = s1_mask_q;
        s2_last_d = s1_last_q;
        issue     = 1'b0;
        src_cur   = cur_q;
        src_rem   = rem_q;

        // FIFO bookkeeping first; DRAIN looks at the post-pop count.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        hold_data_d = hold_data_q;
        fifo_cnt_d  = fifo_cnt_q + CntW'(push) - CntW'(pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            hold_data_d = head[2*DATA_W-1:0];
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_cur = base_addr;
                    src_rem = count;
                    // The pipeline is always empty in IDLE, so the first read
                    // issues on the same edge that accepts the command.
                    if (count != '0) begin
                        issue   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFetch: begin
                if (rem_q == '0) begin
                    state_d = StDrain;
                end else if (used < (CntW+1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                end
            end
            StDrain: begin
                if (!s1_vld_q && !s2_vld_q && fifo_cnt_d == '0) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        step     = (src_rem >= (ADDR_W+1)'(2)) ? (ADDR_W+1)'(2) : src_rem;
        s1_vld_d = issue;
        if (issue) begin
            addr_a_d  = src_cur;
            addr_b_d  = src_cur + ADDR_W'(1);
            cur_d     = src_cur + ADDR_W'(2);
            rem_d     = src_rem - step;
            s1_mask_d = (src_rem >= (ADDR_W+1)'(2)) ? 2'b11 : 2'b01;
            s1_last_d = (src_rem <= (ADDR_W+1)'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            rem_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_mask_q   <= '0;
            s1_last_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_mask_q   <= '0;
            s2_last_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            s1_vld_q    <= s1_vld_d;
            s1_mask_q   <= s1_mask_d;
            s1_last_q   <= s1_last_d;
            s2_vld_q    <= s2_vld_d;
            s2_mask_q   <= s2_mask_d;
            s2_last_q   <= s2_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef BURST_READER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && start) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ramb18_burst_reader.sv
// Bench for ramb18_burst_reader: a registered-read memory model (mem[i] = i),
// a scoreboard queue of expected beats filled when each burst is commanded,
// a table of bursts, and hand-written sequences for the multi-cycle corners.
module tb_ramb18_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] count = '0;
    logic        busy, done;
    logic [9:0]  read_addr_a, read_addr_b;
    logic [17:0] read_data_a, read_data_b;
    logic [35:0] out_data;
    logic [1:0]  out_mask;
    logic        out_last, out_valid;
    logic        out_ready = 1'b1;
`ifdef BURST_READER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    ramb18_burst_reader #(
        .ADDR_W    (10),
        .DATA_W    (18),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .read_addr_a (read_addr_a),
        .read_data_a (read_data_a),
        .read_addr_b (read_addr_b),
        .read_data_b (read_data_b),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .out_last    (out_last),
        .out_valid   (out_valid),
`ifdef BURST_READER_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Buffer model with one-cycle registered read.
    logic [17:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = 18'(i);
    always @(posedge clk) begin
        read_data_a <= mem[read_addr_a];
        read_data_b <= mem[read_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fails = 0;
    int beat_total = 0;
    int done_total = 0;
    int last_cyc = 0;
    int done_cyc = 0;
    logic [38:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: each handshake pops one expected {last, mask, data}.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_total++;
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("beat", 64'({out_last, out_mask, out_data}), 64'(exp_q.pop_front()));
            end
            if (out_last) last_cyc = cyc;
        end
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    task automatic push_expected(input int base, input int cnt);
        logic [17:0] w0, w1;
        logic [1:0]  m;
        logic        lst;
        for (int i = 0; i < cnt; i += 2) begin
            w0 = mem[(base + i) % 1024];
            if (i + 1 < cnt) begin
                w1 = mem[(base + i + 1) % 1024];
                m  = 2'b11;
            end else begin
                w1 = '0;
                m  = 2'b01;
            end
            lst = (i + 2 >= cnt);
            exp_q.push_back({lst, m, w1, w0});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drives a start pulse across one edge; returns the cycle index of that edge.
    task automatic issue_start(input int base, input int cnt, output int s_cyc);
        @(posedge clk);
        #1;
        base_addr = 10'(base);
        count     = 11'(cnt);
        start     = 1'b1;
        s_cyc     = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        for (int i = 0; i < bound && done_total == d0; i++) tick();
        check("done_seen", 64'(done_total > d0), 64'd1);
    endtask

    task automatic wait_first_valid(input int s_cyc, input string name);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_latency"}, 64'(cyc - s_cyc), 64'd2);
    endtask

    task automatic run_burst(input int base, input int cnt, input int beats);
        int b0, d0, s_cyc;
        b0 = beat_total;
        d0 = done_total;
        push_expected(base, cnt);
        issue_start(base, cnt, s_cyc);
        wait_first_valid(s_cyc, "first");
        wait_done(d0, 3000);
        check("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
        tick();
        tick();
        check("beat_count", 64'(beat_total - b0), 64'(beats));
        check("done_once", 64'(done_total - d0), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int base;
        int cnt;
        int beats;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int   s_cyc, b0, d0;
        logic [35:0] held;

        vecs[0] = '{base: 0,    cnt: 8,    beats: 4};
        vecs[1] = '{base: 1020, cnt: 7,    beats: 4};
        vecs[2] = '{base: 100,  cnt: 2,    beats: 1};
        vecs[3] = '{base: 5,    cnt: 1,    beats: 1};
        vecs[4] = '{base: 1023, cnt: 3,    beats: 2};
        vecs[5] = '{base: 37,   cnt: 9,    beats: 5};
        vecs[6] = '{base: 700,  cnt: 1024, beats: 512};

        repeat (3) @(posedge clk);
        tick();
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done), 64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_data",   64'(out_data), 64'd0);
        check("rst_mask",   64'(out_mask), 64'd0);
        check("rst_last",   64'(out_last), 64'd0);
        check("rst_addr_a", 64'(read_addr_a), 64'd0);
        check("rst_addr_b", 64'(read_addr_b), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_burst(vecs[v].base, vecs[v].cnt, vecs[v].beats);

        // Backpressure: 10 stalled cycles with the FIFO full.
        b0 = beat_total;
        d0 = done_total;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_expected(0, 16);
        issue_start(0, 16, s_cyc);
        wait_first_valid(s_cyc, "stall_first");
        held = out_data;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("stall_hold", 64'(out_data), 64'(held));
        end
        check("stall_valid",  64'(out_valid), 64'd1);
        check("stall_addr_a", 64'(read_addr_a), 64'd6);
        check("stall_addr_b", 64'(read_addr_b), 64'd7);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(d0, 200);
        check("stall_done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
        check("stall_beats", 64'(beat_total - b0), 64'd8);
`ifdef BURST_READER_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'd10);
`endif
        tick();

        // count == 0: one FIN cycle, no data.
        d0 = done_total;
        check("zero_pre_busy", 64'(busy), 64'd0);
        issue_start(0, 0, s_cyc);
        tick();
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done", 64'(done), 64'd1);
        check("zero_valid", 64'(out_valid), 64'd0);
        tick();
        check("zero_busy_off", 64'(busy), 64'd0);
        check("zero_done_off", 64'(done), 64'd0);
        check("zero_done_once", 64'(done_total - d0), 64'd1);

        // Start while busy is ignored.
        b0 = beat_total;
        d0 = done_total;
        push_expected(0, 8);
        issue_start(0, 8, s_cyc);
        base_addr = 10'd500;
        count     = 11'd4;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, 200);
        repeat (5) tick();
        check("ign_beats", 64'(beat_total - b0), 64'd4);
        check("ign_done_once", 64'(done_total - d0), 64'd1);
        check("ign_sb_drained", 64'(exp_q.size()), 64'd0);
        check("ign_busy", 64'(busy), 64'd0);

        // Reset mid-burst.
        b0 = beat_total;
        d0 = done_total;
        push_expected(0, 16);
        issue_start(0, 16, s_cyc);
        for (int i = 0; i < 50 && beat_total - b0 < 2; i++) tick();
        check("mid_two_beats", 64'(beat_total - b0 >= 2), 64'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        check("mid_rst_no_done", 64'(done_total - d0), 64'd0);
        check("mid_rst_idle_valid", 64'(out_valid), 64'd0);
        run_burst(100, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
        $fatal(1);
    end

endmodule
